load_unit: RTL and testbench

- Memory-stage load controller; the read-side counterpart of the data memory's store path.
- Accepts a load (address, type, PC) from the MEM stage and checks alignment and address range.
- Issues a word-aligned read on the req/ack data bus (DM or timers), then byte/half-selects and sign/zero-extends the returned word.
- Stalls the pipeline for the duration and reports AdEL (misaligned or out of range) and DBE (bus timeout/error) exceptions to CP0.

---
 rtl/load_unit.sv | 206 ++++++++++++++++++++
 tb/tb_load_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: memory-stage load controller.
// Checks the load for alignment and address range, issues one word-aligned
// read on the req/ack data bus, then selects and extends the returned byte,
// half or word. Stalls the pipeline while busy and reports AdEL/DBE to CP0.
//
// state | meaning
// IDLE  | waiting for a load from the MEM stage
// REQ   | bus read outstanding, timeout counter running
// DONE  | ld_done pulse with the extended result
// FAULT | ld_done pulse with ld_exc, exc_code, bad_vaddr, exc_pc
module load_unit #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] DM_TOP  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_pc,
  input  logic        flush,
  output logic        ld_stall,
  output logic        ld_done,
  output logic [31:0] ld_data,
  output logic        ld_exc,
  output logic [4:0]  exc_code,
  output logic [31:0] bad_vaddr,
  output logic [31:0] exc_pc,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_type;
  logic [31:0] r_pc;
  logic [7:0]  r_cnt;
  logic        r_bus_req;
  logic [31:0] r_bus_addr;
  logic        r_done;
  logic        r_exc;
  logic [4:0]  r_code;
  logic [31:0] r_data;
  logic [31:0] r_bva;
  logic [31:0] r_epc;

  logic        w_in_dm;
  logic        w_in_tmr;
  logic        w_type_ok;
  logic        w_align_ok;
  logic        w_legal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  assign w_in_dm  = (ld_addr < DM_TOP);
  assign w_in_tmr = ((ld_addr >= 32'h0000_7F00) && (ld_addr <= 32'h0000_7F0B)) ||
                    ((ld_addr >= 32'h0000_7F10) && (ld_addr <= 32'h0000_7F1B));

  // Type and alignment legality of the incoming load; timers take lw only.
  always_comb begin
    w_type_ok  = 1'b0;
    w_align_ok = 1'b0;
    case (ld_type)
      3'b000, 3'b100: begin
        w_type_ok  = 1'b1;
        w_align_ok = 1'b1;
      end
      3'b001, 3'b101: begin
        w_type_ok  = 1'b1;
        w_align_ok = ~ld_addr[0];
      end
      3'b011: begin
        w_type_ok  = 1'b1;
        w_align_ok = (ld_addr[1:0] == 2'b00);
      end
      default: begin
        w_type_ok  = 1'b0;
        w_align_ok = 1'b0;
      end
    endcase
  end

  assign w_legal = w_type_ok && w_align_ok &&
                   (w_in_dm || (w_in_tmr && (ld_type == 3'b011)));

  // Byte/half select from the returned word and sign/zero extension.
  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = bus_rdata[7:0];
      2'd1: w_byte = bus_rdata[15:8];
      2'd2: w_byte = bus_rdata[23:16];
      2'd3: w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    w_ext  = bus_rdata;
    case (r_type)
      3'b000: w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100: w_ext = {24'h0, w_byte};
      3'b001: w_ext = {{16{w_half[15]}}, w_half};
      3'b101: w_ext = {16'h0, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  // Load sequencing FSM; all status outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'h0;
      r_type     <= 3'b000;
      r_pc       <= 32'h0;
      r_cnt      <= 8'h0;
      r_bus_req  <= 1'b0;
      r_bus_addr <= 32'h0;
      r_done     <= 1'b0;
      r_exc      <= 1'b0;
      r_code     <= 5'd0;
      r_data     <= 32'h0;
      r_bva      <= 32'h0;
      r_epc      <= 32'h0;
    end else begin
      r_done <= 1'b0;
      r_exc  <= 1'b0;
      r_code <= 5'd0;
      r_bva  <= 32'h0;
      r_epc  <= 32'h0;
      case (r_state)
        S_IDLE: begin
          if (ld_valid && !flush) begin
            r_addr <= ld_addr;
            r_type <= ld_type;
            r_pc   <= ld_pc;
            if (w_legal) begin
              r_state    <= S_REQ;
              r_bus_req  <= 1'b1;
              r_bus_addr <= {ld_addr[31:2], 2'b00};
            end else begin
              r_state <= S_FAULT;
              r_done  <= 1'b1;
              r_exc   <= 1'b1;
              r_code  <= EXC_ADEL;
              r_bva   <= ld_addr;
              r_epc   <= ld_pc;
              r_data  <= 32'h0;
            end
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (flush) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'h0;
            r_bus_req  <= 1'b0;
            r_bus_addr <= 32'h0;
          end else if (bus_ack) begin
            r_state    <= S_DONE;
            r_cnt      <= 8'h0;
            r_bus_req  <= 1'b0;
            r_bus_addr <= 32'h0;
            r_data     <= w_ext;
            r_done     <= 1'b1;
          end else if (bus_err || (r_cnt == CNT_LAST)) begin
            // DBE reports the original byte address, not the aligned one.
            r_state    <= S_FAULT;
            r_cnt      <= 8'h0;
            r_bus_req  <= 1'b0;
            r_bus_addr <= 32'h0;
            r_done     <= 1'b1;
            r_exc      <= 1'b1;
            r_code     <= EXC_DBE;
            r_bva      <= r_addr;
            r_epc      <= r_pc;
            r_data     <= 32'h0;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush in DONE/FAULT suppresses the completion report.
  assign ld_done   = r_done & ~flush;
  assign ld_exc    = r_exc & ~flush;
  assign exc_code  = flush ? 5'd0 : r_code;
  assign ld_data   = r_data;
  assign bad_vaddr = r_bva;
  assign exc_pc    = r_epc;
  assign bus_req   = r_bus_req;
  assign bus_addr  = r_bus_addr;
  assign ld_stall  = ((r_state == S_IDLE) && ld_valid && !flush) || (r_state == S_REQ);

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed vectors for load_unit with hand-computed results.
// u_big has DM_TOP raised to 0x4000, u_def keeps the default 0x3000; both
// see the same stimulus and use_def picks which one is observed.
module tb_load_unit;
  logic        clk = 1'b0;
  logic        reset, ld_valid, flush, bus_ack, bus_err;
  logic [31:0] ld_addr, ld_pc, bus_rdata;
  logic [2:0]  ld_type;

  logic        a_stall, a_done, a_exc, a_breq;
  logic [4:0]  a_code;
  logic [31:0] a_data, a_bva, a_epc, a_baddr;
  logic        d_stall, d_done, d_exc, d_breq;
  logic [4:0]  d_code;
  logic [31:0] d_data, d_bva, d_epc, d_baddr;

  logic        use_def = 1'b0;
  logic        m_stall, m_done, m_exc, m_breq;
  logic [4:0]  m_code;
  logic [31:0] m_data, m_bva, m_epc, m_baddr;

  assign m_stall = use_def ? d_stall : a_stall;
  assign m_done  = use_def ? d_done  : a_done;
  assign m_exc   = use_def ? d_exc   : a_exc;
  assign m_breq  = use_def ? d_breq  : a_breq;
  assign m_code  = use_def ? d_code  : a_code;
  assign m_data  = use_def ? d_data  : a_data;
  assign m_bva   = use_def ? d_bva   : a_bva;
  assign m_epc   = use_def ? d_epc   : a_epc;
  assign m_baddr = use_def ? d_baddr : a_baddr;

  load_unit #(.TIMEOUT(16), .DM_TOP(32'h0000_4000)) u_big (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_type(ld_type), .ld_pc(ld_pc), .flush(flush), .ld_stall(a_stall),
    .ld_done(a_done), .ld_data(a_data), .ld_exc(a_exc), .exc_code(a_code),
    .bad_vaddr(a_bva), .exc_pc(a_epc), .bus_req(a_breq), .bus_addr(a_baddr),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err));

  load_unit u_def (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_type(ld_type), .ld_pc(ld_pc), .flush(flush), .ld_stall(d_stall),
    .ld_done(d_done), .ld_data(d_data), .ld_exc(d_exc), .exc_code(d_code),
    .bad_vaddr(d_bva), .exc_pc(d_epc), .bus_req(d_breq), .bus_addr(d_baddr),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mid();
      ld_valid = 1'b0;
      flush    = 1'b0;
      bus_ack  = 1'b0;
      bus_err  = 1'b0;
    end
  endtask

  // Holds one load on the inputs until ld_done; the bus answers in the
  // ack_n-th REQ cycle (0 = never) with ack, or with err when use_err is set.
  task automatic run_load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] pc,
                          input int ack_n, input bit use_err, input logic [31:0] w,
                          output int done_at, output int nstall, output int nreq,
                          output logic [31:0] data, output logic exc, output logic [4:0] code,
                          output logic [31:0] bva, output logic [31:0] epc,
                          output logic [31:0] baddr, output logic breq_done, output int gdone);
    done_at = 0; nstall = 0; nreq = 0; data = 32'h0; exc = 1'b0; code = 5'd0;
    bva = 32'h0; epc = 32'h0; baddr = 32'h0; breq_done = 1'b0; gdone = 0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      mid();
      ld_valid = 1'b1; ld_addr = a; ld_type = t; ld_pc = pc; flush = 1'b0;
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = w;
      if (m_breq) begin
        nreq++;
        if (nreq == 1) baddr = m_baddr;
        if (nreq == ack_n) begin
          if (use_err) bus_err = 1'b1;
          else bus_ack = 1'b1;
        end
      end
      #1;
      if (m_stall) nstall++;
      if (m_done) begin
        done_at = k; data = m_data; exc = m_exc; code = m_code;
        bva = m_bva; epc = m_epc; breq_done = m_breq; gdone = cyc;
      end
    end
  endtask

  int          dn, ns, nr, g1, g2;
  logic [31:0] dat, bv, ep, ba;
  logic        ex, brd;
  logic [4:0]  cd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ld_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    ld_addr = 32'h0; ld_pc = 32'h0; ld_type = 3'b000; bus_rdata = 32'h0;
    idle(3);
    mid(); reset = 1'b0; #1;
    chk("rst_stall", a_stall, 0);
    chk("rst_done", a_done, 0);
    chk("rst_breq", a_breq, 0);
    chk("rst_data", a_data, 0);
    chk("rst_code", a_code, 0);

    // DM word 0x3000 = 0x8081_7F22 on the raised-DM_TOP instance
    run_load(32'h3001, 3'b000, 32'h100, 1, 0, 32'h8081_7F22, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("lb_3001_cyc", dn, 3);
    chk("lb_3001_data", dat, 32'h0000_007F);
    chk("lb_3001_exc", ex, 0);
    chk("lb_3001_baddr", ba, 32'h3000);
    run_load(32'h3003, 3'b000, 32'h104, 1, 0, 32'h8081_7F22, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("lb_3003_data", dat, 32'hFFFF_FF80);
    run_load(32'h3003, 3'b100, 32'h108, 1, 0, 32'h8081_7F22, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("lbu_3003_data", dat, 32'h0000_0080);
    run_load(32'h3002, 3'b101, 32'h10C, 1, 0, 32'h8081_7F22, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("lhu_3002_data", dat, 32'h0000_8081);
    idle(2);

    // Address errors
    run_load(32'h0000_0006, 3'b011, 32'h0040_0100, 0, 0, 32'h0, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("adel_lw6_cyc", dn, 2);
    chk("adel_lw6_nreq", nr, 0);
    chk("adel_lw6_exc", ex, 1);
    chk("adel_lw6_code", cd, 4);
    chk("adel_lw6_bva", bv, 32'h6);
    chk("adel_lw6_epc", ep, 32'h0040_0100);
    chk("adel_lw6_data", dat, 0);
    run_load(32'h7F04, 3'b001, 32'h200, 0, 0, 32'h0, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("adel_lh_tmr_code", cd, 4);
    chk("adel_lh_tmr_nreq", nr, 0);
    run_load(32'h0010, 3'b010, 32'h204, 0, 0, 32'h0, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("adel_type_code", cd, 4);
    idle(2);
    use_def = 1'b1;
    run_load(32'h3000, 3'b011, 32'h208, 0, 0, 32'h0, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("adel_dmtop_exc", ex, 1);
    chk("adel_dmtop_code", cd, 4);
    chk("adel_dmtop_bva", bv, 32'h3000);
    use_def = 1'b0;
    idle(22);

    // Delayed ack from timer
    run_load(32'h7F04, 3'b011, 32'h300, 5, 0, 32'h1234_5678, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("tmr_lw_stall", ns, 6);
    chk("tmr_lw_baddr", ba, 32'h7F04);
    chk("tmr_lw_data", dat, 32'h1234_5678);
    chk("tmr_lw_cyc", dn, 7);

    // Bus timeout
    run_load(32'h7F10, 3'b011, 32'h304, 0, 0, 32'h0, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("tmo_nreq", nr, 16);
    chk("tmo_cyc", dn, 18);
    chk("tmo_code", cd, 7);
    chk("tmo_bva", bv, 32'h7F10);
    chk("tmo_epc", ep, 32'h304);
    chk("tmo_breq_low", brd, 0);
    chk("tmo_data_zero", dat, 0);

    // Bus error reports the byte address
    run_load(32'h0005, 3'b000, 32'h308, 2, 1, 32'h0, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("berr_cyc", dn, 4);
    chk("berr_code", cd, 7);
    chk("berr_bva", bv, 32'h5);

    // Back-to-back halfword loads
    run_load(32'h0000, 3'b001, 32'h400, 1, 0, 32'h0000_FFFE, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g1);
    chk("lh0_data", dat, 32'hFFFF_FFFE);
    chk("lh0_cyc", dn, 3);
    run_load(32'h0002, 3'b001, 32'h404, 1, 0, 32'h7FFF_0000, dn, ns, nr, dat, ex, cd, bv, ep, ba, brd, g2);
    chk("lh2_data", dat, 32'h0000_7FFF);
    chk("lh2_cyc", dn, 3);
    chk("lh_spacing", g2 - g1, 3);

    // Flush in 2nd REQ cycle with a simultaneous ack
    mid(); ld_valid = 1'b1; ld_addr = 32'h7F08; ld_type = 3'b011; ld_pc = 32'h500; flush = 1'b0; bus_ack = 1'b0; #1;
    chk("fl_idle_stall", a_stall, 1);
    mid(); #1;
    chk("fl_req1_breq", a_breq, 1);
    mid(); flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
    chk("fl_req2_done", a_done, 0);
    mid(); flush = 1'b0; bus_ack = 1'b0; ld_valid = 1'b0; #1;
    chk("fl_after_done", a_done, 0);
    chk("fl_after_breq", a_breq, 0);
    chk("fl_after_stall", a_stall, 0);
    chk("fl_after_data", a_data, 32'h0000_7FFF);

    // Flush in DONE gates the completion
    mid(); ld_valid = 1'b1; ld_addr = 32'h7F08; #1;
    mid(); bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; #1;
    mid(); bus_ack = 1'b0; flush = 1'b1; #1;
    chk("fld_done", a_done, 0);
    chk("fld_exc", a_exc, 0);
    chk("fld_data", a_data, 32'hCAFE_F00D);
    mid(); flush = 1'b0; ld_valid = 1'b0; #1;
    chk("fld_idle_breq", a_breq, 0);

    // Reset in 2nd REQ cycle with a simultaneous ack
    mid(); ld_valid = 1'b1; ld_addr = 32'h7F08; #1;
    mid(); #1;
    mid(); reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1111_1111; #1;
    mid(); reset = 1'b0; bus_ack = 1'b0; ld_valid = 1'b0; #1;
    chk("rs_breq", a_breq, 0);
    chk("rs_baddr", a_baddr, 0);
    chk("rs_done", a_done, 0);
    chk("rs_data", a_data, 0);
    chk("rs_exc", a_exc, 0);
    chk("rs_stall", a_stall, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
